// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_unit : decode-stage stall / forwarding control with stall counter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_unit #(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] NOWR_REG = 5'd30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       opcode_ID,
  input  logic [4:0]       Rp_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             RegWr_ID,
  input  logic             MemRd_ID,
  input  logic [4:0]       Dest_ID,
  output logic             stall,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0]       c_op_jr    = 5'd13;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic             r_ex_wr, r_ex_ld, r_mem_wr, r_mem_ld, r_wb_wr, r_wb_ld;
  logic [4:0]       r_ex_dst, r_mem_dst, r_wb_dst;
  logic [CNT_W-1:0] r_stall_count;

  logic w_use_a, w_use_b, w_use_jr, w_use_p;
  logic w_ex_rs, w_mem_rs, w_wb_rs;
  logic w_ex_rt, w_mem_rt, w_wb_rt;
  logic w_ex_rp, w_mem_rp, w_wb_rp;
  logic w_stall;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Register 0 and NOWR_REG are never written, so they never create a hazard.
  function automatic logic writes_reg(input logic wr, input logic [4:0] dst,
                                      input logic [4:0] r);
    return wr && (dst == r) && (r != 5'd0) && (r != NOWR_REG);
  endfunction

  assign w_use_a  = id_valid && (opcode_ID <= 5'd10);
  assign w_use_b  = id_valid && ((opcode_ID <= 5'd4) || (opcode_ID == 5'd10));
  assign w_use_jr = id_valid && (opcode_ID == c_op_jr);
  assign w_use_p  = id_valid && (Rp_ID != 5'd0);

  assign w_ex_rs  = writes_reg(r_ex_wr,  r_ex_dst,  Rs_ID);
  assign w_mem_rs = writes_reg(r_mem_wr, r_mem_dst, Rs_ID);
  assign w_wb_rs  = writes_reg(r_wb_wr,  r_wb_dst,  Rs_ID);
  assign w_ex_rt  = writes_reg(r_ex_wr,  r_ex_dst,  Rt_ID);
  assign w_mem_rt = writes_reg(r_mem_wr, r_mem_dst, Rt_ID);
  assign w_wb_rt  = writes_reg(r_wb_wr,  r_wb_dst,  Rt_ID);
  assign w_ex_rp  = writes_reg(r_ex_wr,  r_ex_dst,  Rp_ID);
  assign w_mem_rp = writes_reg(r_mem_wr, r_mem_dst, Rp_ID);
  assign w_wb_rp  = writes_reg(r_wb_wr,  r_wb_dst,  Rp_ID);

  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (w_use_a) begin
      if (w_ex_rs)       w_fwd_a = 2'd1;
      else if (w_mem_rs) w_fwd_a = 2'd2;
      else if (w_wb_rs)  w_fwd_a = 2'd3;
    end
    if (w_use_b) begin
      if (w_ex_rt)       w_fwd_b = 2'd1;
      else if (w_mem_rt) w_fwd_b = 2'd2;
      else if (w_wb_rt)  w_fwd_b = 2'd3;
    end
  end

  // Predicate and JR operands bypass the forwarding muxes, so they must wait
  // until the producer has left WB.
  always_comb begin
    w_stall = 1'b0;
    if (r_ex_ld && ((w_use_a && w_ex_rs) || (w_use_b && w_ex_rt)))
      w_stall = 1'b1;
    if (w_use_p && (w_ex_rp || w_mem_rp || w_wb_rp))
      w_stall = 1'b1;
    if (w_use_jr && (w_ex_rs || w_mem_rs || w_wb_rs))
      w_stall = 1'b1;
  end

  assign stall       = reset ? w_stall : 1'b0;
  assign ForwardA    = reset ? w_fwd_a : 2'd0;
  assign ForwardB    = reset ? w_fwd_b : 2'd0;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_wr       <= 1'b0;
      r_ex_ld       <= 1'b0;
      r_ex_dst      <= 5'd0;
      r_mem_wr      <= 1'b0;
      r_mem_ld      <= 1'b0;
      r_mem_dst     <= 5'd0;
      r_wb_wr       <= 1'b0;
      r_wb_ld       <= 1'b0;
      r_wb_dst      <= 5'd0;
      r_stall_count <= '0;
    end else begin
      r_wb_wr   <= r_mem_wr;
      r_wb_ld   <= r_mem_ld;
      r_wb_dst  <= r_mem_dst;
      r_mem_wr  <= r_ex_wr;
      r_mem_ld  <= r_ex_ld;
      r_mem_dst <= r_ex_dst;
      if (id_valid && !w_stall) begin
        r_ex_wr  <= RegWr_ID;
        r_ex_ld  <= MemRd_ID;
        r_ex_dst <= Dest_ID;
      end else begin
        r_ex_wr  <= 1'b0;
        r_ex_ld  <= 1'b0;
        r_ex_dst <= 5'd0;
      end
      if (w_stall && (r_stall_count != c_cnt_max))
        r_stall_count <= r_stall_count + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// Directed table-driven bench for hazard_unit, plus reset and saturation sequences.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, RegWr_ID, MemRd_ID;
  logic [4:0]  opcode_ID, Rp_ID, Rs_ID, Rt_ID, Dest_ID;
  logic        stall, stall2;
  logic [1:0]  ForwardA, ForwardB, fa2, fb2;
  logic [15:0] stall_count;
  logic [1:0]  cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16), .NOWR_REG(5'd30)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode_ID(opcode_ID),
    .Rp_ID(Rp_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .RegWr_ID(RegWr_ID),
    .MemRd_ID(MemRd_ID), .Dest_ID(Dest_ID), .stall(stall),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_count(stall_count)
  );

  // Narrow counter copy used only to observe saturation.
  hazard_unit #(.CNT_W(2), .NOWR_REG(5'd30)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode_ID(opcode_ID),
    .Rp_ID(Rp_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .RegWr_ID(RegWr_ID),
    .MemRd_ID(MemRd_ID), .Dest_ID(Dest_ID), .stall(stall2),
    .ForwardA(fa2), .ForwardB(fb2), .stall_count(cnt2)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  op, rp, rs, rt;
    logic        wr, ld;
    logic [4:0]  dst;
    logic        e_stall;
    logic [1:0]  e_fa, e_fb;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, rp, rs, rt,
                              input logic wr, ld, input logic [4:0] dst,
                              input logic es, input logic [1:0] fa, fb,
                              input logic [15:0] cnt);
    vec_t v;
    v.valid = 1'b1; v.op = op; v.rp = rp; v.rs = rs; v.rt = rt;
    v.wr = wr; v.ld = ld; v.dst = dst;
    v.e_stall = es; v.e_fa = fa; v.e_fb = fb; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one ID instruction for one cycle and check the outputs mid-cycle.
  task automatic run(input string nm, input vec_t v);
    id_valid = v.valid; opcode_ID = v.op; Rp_ID = v.rp; Rs_ID = v.rs;
    Rt_ID = v.rt; RegWr_ID = v.wr; MemRd_ID = v.ld; Dest_ID = v.dst;
    @(negedge clk);
    chk({nm, " stall"}, {15'd0, stall}, {15'd0, v.e_stall});
    chk({nm, " ForwardA"}, {14'd0, ForwardA}, {14'd0, v.e_fa});
    chk({nm, " ForwardB"}, {14'd0, ForwardB}, {14'd0, v.e_fb});
    chk({nm, " stall_count"}, stall_count, v.e_cnt);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[32];

  initial begin
    // op rp rs rt wr ld dst | stall fa fb cnt
    tbl[0]  = mk(0, 0, 1, 2, 1, 0, 3,   0, 0, 0, 0);  // ADD R3
    tbl[1]  = mk(0, 0, 3, 9, 1, 0, 8,   0, 1, 0, 0);  // Rs=R3 from EX
    tbl[2]  = mk(0, 0, 3, 0, 1, 0, 10,  0, 2, 0, 0);  // from MEM
    tbl[3]  = mk(0, 0, 3, 3, 1, 0, 11,  0, 3, 3, 0);  // from WB
    tbl[4]  = mk(0, 0, 3, 2, 1, 0, 12,  0, 0, 0, 0);  // retired
    tbl[5]  = mk(5, 0, 1, 0, 1, 1, 5,   0, 0, 0, 0);  // LW R5
    tbl[6]  = mk(2, 0, 2, 5, 1, 0, 6,   1, 0, 1, 0);  // OR load-use
    tbl[7]  = mk(2, 0, 2, 5, 1, 0, 6,   0, 0, 2, 1);
    tbl[8]  = mk(11, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);  // NOP
    tbl[9]  = mk(6, 0, 1, 0, 1, 0, 4,   0, 0, 0, 1);  // ADDI R4
    tbl[10] = mk(1, 4, 6, 2, 1, 0, 13,  1, 3, 0, 1);  // SUB pred R4
    tbl[11] = mk(1, 4, 6, 2, 1, 0, 13,  1, 0, 0, 2);
    tbl[12] = mk(1, 4, 6, 2, 1, 0, 13,  1, 0, 0, 3);
    tbl[13] = mk(1, 4, 6, 2, 1, 0, 13,  0, 0, 0, 4);
    tbl[14] = mk(0, 0, 1, 2, 1, 0, 7,   0, 0, 0, 4);  // ADD R7
    tbl[15] = mk(13, 0, 7, 0, 0, 0, 0,  1, 0, 0, 4);  // JR R7
    tbl[16] = mk(13, 0, 7, 0, 0, 0, 0,  1, 0, 0, 5);
    tbl[17] = mk(13, 0, 7, 0, 0, 0, 0,  1, 0, 0, 6);
    tbl[18] = mk(13, 0, 7, 0, 0, 0, 0,  0, 0, 0, 7);
    tbl[19] = mk(13, 0, 7, 0, 0, 0, 0,  0, 0, 0, 7);  // no writer of R7
    tbl[20] = mk(0, 0, 1, 2, 1, 0, 0,   0, 0, 0, 7);  // Dest=0
    tbl[21] = mk(0, 0, 1, 2, 1, 0, 30,  0, 0, 0, 7);  // Dest=NOWR
    tbl[22] = mk(0, 0, 1, 2, 0, 0, 9,   0, 0, 0, 7);  // RegWr=0 to R9
    tbl[23] = mk(0, 0, 0, 30, 1, 0, 14, 0, 0, 0, 7);  // reads R0, R30
    tbl[24] = mk(0, 0, 9, 1, 1, 0, 15,  0, 0, 0, 7);  // reads R9
    tbl[25] = mk(0, 0, 1, 2, 1, 0, 3,   0, 0, 0, 7);  // ADD R3
    tbl[26] = mk(0, 0, 1, 2, 1, 0, 3,   0, 0, 0, 7);  // ADD R3
    tbl[27] = mk(0, 0, 3, 3, 1, 0, 16,  0, 1, 1, 7);  // EX beats MEM
    tbl[28] = mk(6, 0, 1, 0, 1, 0, 20,  0, 0, 0, 7);  // ADDI R20
    tbl[29] = mk(5, 0, 1, 0, 1, 1, 20,  0, 0, 0, 7);  // LW R20
    tbl[30] = mk(0, 0, 20, 1, 1, 0, 17, 1, 1, 0, 7);  // LW in EX stalls
    tbl[31] = mk(0, 0, 20, 1, 1, 0, 17, 0, 2, 0, 8);  // load picked in MEM

    // Reset forces outputs low even with a would-be consumer in ID.
    reset = 1'b0;
    id_valid = 1'b1; opcode_ID = 5'd1; Rp_ID = 5'd4; Rs_ID = 5'd4; Rt_ID = 5'd4;
    RegWr_ID = 1'b1; MemRd_ID = 1'b0; Dest_ID = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    run("reset", mk(1, 4, 4, 4, 1, 0, 4, 0, 0, 0, 0));
    chk("reset sat_count", {14'd0, cnt2}, 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Reset in the second cycle of a predicate stall.
    run("rst_seq addi", mk(6, 0, 1, 0, 1, 0, 4, 0, 0, 0, 8));
    run("rst_seq stall1", mk(1, 4, 4, 2, 1, 0, 13, 1, 1, 0, 8));
    reset = 1'b0;
    run("rst_seq in_reset", mk(1, 4, 4, 2, 1, 0, 13, 0, 0, 0, 9));
    reset = 1'b1;
    run("rst_seq released", mk(1, 4, 4, 2, 1, 0, 13, 0, 0, 0, 0));

    // Saturation on the 2-bit copy.
    run("sat addi", mk(6, 0, 1, 0, 1, 0, 4, 0, 0, 0, 0));
    run("sat p1", mk(1, 4, 6, 2, 1, 0, 13, 1, 0, 0, 0));
    run("sat p2", mk(1, 4, 6, 2, 1, 0, 13, 1, 0, 0, 1));
    run("sat p3", mk(1, 4, 6, 2, 1, 0, 13, 1, 0, 0, 2));
    run("sat pdone", mk(1, 4, 6, 2, 1, 0, 13, 0, 0, 0, 3));
    chk("sat count3", {14'd0, cnt2}, 16'd3);
    run("sat add7", mk(0, 0, 1, 2, 1, 0, 7, 0, 0, 0, 3));
    run("sat jr1", mk(13, 0, 7, 0, 0, 0, 0, 1, 0, 0, 3));
    run("sat jr2", mk(13, 0, 7, 0, 0, 0, 0, 1, 0, 0, 4));
    run("sat jr3", mk(13, 0, 7, 0, 0, 0, 0, 1, 0, 0, 5));
    run("sat jrdone", mk(13, 0, 7, 0, 0, 0, 0, 0, 0, 0, 6));
    chk("sat held", {14'd0, cnt2}, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Decode-stage hazard controller for the 5-stage predicated pipeline.
- Keeps its own shadow record of the destination registers of instructions in EX, MEM and WB.
- Drives the ID stage's stall, ForwardA and ForwardB inputs, and counts stall cycles.
- Sits beside the ID stage, fed by ID-stage decode signals; the same stall also freezes the PC and IF/ID.

Parameters:
- CNT_W, 16: width of the saturating stall counter.
- NOWR_REG, 30: register index the register file never writes; it is never a forwarding or stall source.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- id_valid  in  1  ID holds a real instruction; 0 = bubble or killed slot.
- opcode_ID  in  5  opcode of the instruction in ID.
- Rp_ID  in  5  predicate register.
- Rs_ID  in  5  A-source register.
- Rt_ID  in  5  effective B-source register (Rd for SW).
- RegWr_ID  in  1  predicate-gated register-write enable of the instruction in ID.
- MemRd_ID  in  1  predicate-gated load flag.
- Dest_ID  in  5  destination register of the instruction in ID (0 for SW, 31 for CALL).
- stall  out  1  hold IF/ID and PC, insert a bubble into ID/EX.
- ForwardA  out  2  A mux select: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- ForwardB  out  2  B mux select, same encoding as ForwardA.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Shadow pipeline: three slots EX, MEM and WB, each holding {wr, ld, dst}.
  - Each rising edge: WB<=MEM, MEM<=EX.
  - EX<={RegWr_ID, MemRd_ID, Dest_ID} when id_valid=1 and stall=0; otherwise EX<=0 (bubble).
- A slot "writes R" when wr=1 and dst==R, with R != 0 and R != NOWR_REG.
- Operand usage, decoded from opcode_ID and gated by id_valid:
  - useA: opcodes 0-10.
  - useB: opcodes 0-4 and 10.
  - useJR: opcode 13, reads Rs directly from the register file (no forwarding mux).
  - useP: Rp_ID != 0, any opcode.
  - Opcodes 11, 12 and 14-31 use only P.
- ForwardA (combinational):
  - If useA, select the youngest matching slot for Rs_ID: EX gives 1, else MEM gives 2, else WB gives 3.
  - Otherwise 0.
- ForwardB: same rule, using useB and Rt_ID.
- stall (combinational) is 1 when any of the following holds:
  - Load-use: the EX slot has ld=1 and writes Rs_ID (with useA) or Rt_ID (with useB). Lasts 1 cycle, after which the producer is in MEM and Forward=2.
  - Predicate: useP and any of EX, MEM or WB writes Rp_ID. BusP is not forwarded, and the register file write lands at the end of the WB cycle, so this can last up to 3 cycles.
  - JR: useJR and any slot writes Rs_ID. Up to 3 cycles.
- Forward selects are still computed while stalled; ID/EX discards them.
- stall_count increments by 1 on each edge where stall=1 and saturates at all-ones.
- Reset (reset=0 at an edge):
  - All shadow slots cleared and stall_count=0.
  - While reset=0, stall=0 and ForwardA=ForwardB=0 are forced.
  - Reset asserted mid-stall abandons the stall; the next cycle after reset releases evaluates against empty slots.
- Simultaneous matches: EX has priority over MEM, and MEM over WB.
  - A load in EX and an ALU op in MEM writing the same register produce a stall.
  - After that stall the load is in MEM and is selected (Forward=2).
- Producers with RegWr_ID=0 (predicated off, SW, NOP) never forward and never stall.
- Latency: zero-cycle combinational outputs from the registered shadow state plus the current ID inputs.

Test Plan:
- ADD R3 issued, then ADD with Rs=R3 in consecutive cycles -> ForwardA=1, then 2, then 3, then 0 on successive cycles; stall=0 throughout.
- LW R5 followed immediately by OR with Rt=R5 -> stall=1 for exactly 1 cycle, then ForwardB=2 with stall=0; stall_count=1.
- ADDI R4 followed by a predicated SUB with Rp=R4 -> stall=1 for 3 cycles, then 0; stall_count=3; ForwardA/B for the SUB's sources are unaffected.
- JR R7 right after ADD R7 -> 3 stall cycles; JR R7 with no in-flight write to R7 -> stall=0.
- Producers with Dest=0, Dest=30, or RegWr_ID=0 -> consumer sees ForwardA=ForwardB=0 and stall=0. Both EX and MEM writing R3 -> ForwardA=1.
- reset=0 during the second cycle of a predicate stall -> next cycle stall=0, stall_count=0, and shadow slots cleared. stall_count forced from all-ones holds its value when a further stall occurs.
